// File: rtl/diff_hazard_unit_pkg.sv
// Shared definitions for the decode-stage hazard unit: register-address
// width, forwarding-select encoding, the E/M shadow slot record and a
// helper that decides whether a slot produces a given register.
package diff_hazard_unit_pkg;

   // Register-address width; register 0 is hardwired zero.
   localparam int RAW = 5;

   // Operand source selects, shared by adepend, bdepend and sdepend.
   localparam logic [1:0] DEP_RF   = 2'b00;  // register file
   localparam logic [1:0] DEP_EALU = 2'b01;  // E-stage ALU result
   localparam logic [1:0] DEP_MALU = 2'b10;  // M-stage ALU result
   localparam logic [1:0] DEP_MMEM = 2'b11;  // M-stage memory data

   // Destination fields of one in-flight instruction.
   typedef struct packed {
      logic           wreg;
      logic           m2reg;
      logic [RAW-1:0] rd;
   } slot_t;

   // True when the slot will write register r; r0 never matches.
   function automatic logic slot_hit(input slot_t s, input logic [RAW-1:0] r);
      return s.wreg && (s.rd == r) && (r != '0);
   endfunction

endpackage

// File: rtl/diff_dep_sel.sv
// Forwarding source select for one source register. The E slot has
// priority so the youngest producer wins; a load still in E cannot be
// forwarded (the stall logic in the top covers that case).
module diff_dep_sel
   import diff_hazard_unit_pkg::*;
(
   input  logic [RAW-1:0] r,
   input  slot_t          e_slot,
   input  slot_t          m_slot,
   output logic [1:0]     sel
);

   // Priority selection: E ALU result, then M ALU/memory, else register file.
   always_comb begin
      // NOTE: default first so every path assigns sel and no latch is inferred.
      sel = DEP_RF;
      if (slot_hit(e_slot, r) && !e_slot.m2reg) begin
         sel = DEP_EALU;
      end else if (slot_hit(m_slot, r)) begin
         sel = m_slot.m2reg ? DEP_MMEM : DEP_MALU;
      end
   end

endmodule

// File: rtl/diff_hazard_unit.sv
// Decode-stage hazard and forwarding controller for the 5-stage pipeline.
// Tracks the destination fields of the E and M stage instructions and
// produces operand forwarding selects plus a one-cycle load-use stall.
// Optional build macro HAZ_PERF_CNT_EN adds stall_cnt and fwd_cnt
// performance counters as extra output ports.
module diff_hazard_unit
   import diff_hazard_unit_pkg::*;
(
   input  logic           clk,
   input  logic           clrn,
   input  logic [RAW-1:0] rs,
   input  logic [RAW-1:0] rt,
   input  logic           use_rs,
   input  logic           use_rt,
   input  logic           wreg,
   input  logic           m2reg,
   input  logic           wmem,
   input  logic           aluimm,
   input  logic [RAW-1:0] rd,
   input  logic           flush,
   output logic [1:0]     adepend,
   output logic [1:0]     bdepend,
   output logic [1:0]     sdepend,
   output logic           stall,
   output logic           bubble
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]    stall_cnt,
   output logic [31:0]    fwd_cnt
`endif
);

   slot_t      e_slot;
   slot_t      m_slot;
   slot_t      d_slot;
   logic [1:0] a_sel;
   logic [1:0] b_sel;
   logic [1:0] s_sel;

   // A bubbled instruction enters E with all fields zero, so it can never hit.
   assign d_slot = bubble ? '0 : slot_t'{wreg: wreg, m2reg: m2reg, rd: rd};

   // Shadow pipeline of destination fields: D -> E -> M.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         e_slot <= '0;
         m_slot <= '0;
      end else begin
         // NOTE: non-blocking so M captures the old E before E is overwritten.
         m_slot <= e_slot;
         e_slot <= d_slot;
      end
   end

   diff_dep_sel u_a_sel (.r(rs), .e_slot(e_slot), .m_slot(m_slot), .sel(a_sel));
   diff_dep_sel u_b_sel (.r(rt), .e_slot(e_slot), .m_slot(m_slot), .sel(b_sel));
   diff_dep_sel u_s_sel (.r(rt), .e_slot(e_slot), .m_slot(m_slot), .sel(s_sel));

   // Gate each select by whether the D instruction actually uses that operand.
   always_comb begin
      adepend = use_rs             ? a_sel : DEP_RF;
      bdepend = (use_rt && !aluimm) ? b_sel : DEP_RF;
      sdepend = (wmem && use_rt)   ? s_sel : DEP_RF;
   end

   // Load in E feeding the D instruction: hold one cycle until it reaches M.
   always_comb begin
      stall  = e_slot.m2reg && ((use_rs && slot_hit(e_slot, rs)) ||
                                (use_rt && slot_hit(e_slot, rt)));
      bubble = stall || flush;
   end

`ifdef HAZ_PERF_CNT_EN
   logic any_fwd;

   assign any_fwd = !stall && ((adepend != DEP_RF) || (bdepend != DEP_RF) ||
                               (sdepend != DEP_RF));

   // Free-running event counters; both wrap naturally at 32 bits.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
      end else begin
         if (stall)   stall_cnt <= stall_cnt + 32'd1;
         if (any_fwd) fwd_cnt   <= fwd_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_diff_hazard_unit.sv
// Directed self-checking bench for diff_hazard_unit. Inputs change 1 ns
// after the rising edge; combinational outputs are sampled 2 ns later.
module tb_diff_hazard_unit;

   logic       clk;
   logic       clrn;
   logic [4:0] rs, rt, rd;
   logic       use_rs, use_rt, wreg, m2reg, wmem, aluimm, flush;
   logic [1:0] adepend, bdepend, sdepend;
   logic       stall, bubble;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt, fwd_cnt;
`endif

   int checks = 0;
   int errors = 0;

   diff_hazard_unit dut (
      .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
      .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .aluimm(aluimm), .rd(rd),
      .flush(flush), .adepend(adepend), .bdepend(bdepend), .sdepend(sdepend),
      .stall(stall), .bubble(bubble)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one D-stage instruction and let the combinational outputs settle.
   task automatic drive(input logic [4:0] rs_v, input logic [4:0] rt_v,
                        input logic urs, input logic urt, input logic wr,
                        input logic ld, input logic st, input logic imm,
                        input logic [4:0] rd_v, input logic fl);
      rs = rs_v; rt = rt_v; use_rs = urs; use_rt = urt; wreg = wr;
      m2reg = ld; wmem = st; aluimm = imm; rd = rd_v; flush = fl;
      #2;
   endtask

   task automatic nop();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset away from the clock edge, leaving the slots empty.
   task automatic do_reset();
      @(negedge clk);
      clrn = 1'b0;
      nop();
      clrn = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      clrn = 1'b0;
      drive(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1);
      checks++;
      if ({adepend, bdepend, sdepend, stall, bubble} !== 8'b00_00_00_0_1) begin
         errors++;
         $display("FAIL reset_flush: got a=%b b=%b s=%b stall=%b bubble=%b, want 00 00 00 0 1",
                  adepend, bdepend, sdepend, stall, bubble);
      end
      drive(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
      checks++;
      if (bubble !== 1'b0) begin
         errors++;
         $display("FAIL reset_noflush: got bubble=%b, want 0", bubble);
      end
      clrn = 1'b1;
      tick();
   endtask

   task automatic test_empty();
      do_reset();
      drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (adepend !== 2'b00 || stall !== 1'b0) begin
         errors++;
         $display("FAIL empty_slots: got a=%b stall=%b, want 00 0", adepend, stall);
      end
      tick();
   endtask

   task automatic test_forward_e();
      do_reset();
      drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0); // add r5
      tick();
      drive(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0); // sub r6,r5,r5
      checks++;
      if (adepend !== 2'b01 || bdepend !== 2'b01 || sdepend !== 2'b00 || stall !== 1'b0) begin
         errors++;
         $display("FAIL fwd_e: got a=%b b=%b s=%b stall=%b, want 01 01 00 0",
                  adepend, bdepend, sdepend, stall);
      end
      drive(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0); // immediate B
      checks++;
      if (adepend !== 2'b01 || bdepend !== 2'b00) begin
         errors++;
         $display("FAIL fwd_e_aluimm: got a=%b b=%b, want 01 00", adepend, bdepend);
      end
      tick();
   endtask

   task automatic test_forward_m();
      do_reset();
      drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0); // add r5
      tick();
      nop();
      tick();
      drive(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0);
      checks++;
      if (adepend !== 2'b10 || bdepend !== 2'b10 || stall !== 1'b0) begin
         errors++;
         $display("FAIL fwd_m: got a=%b b=%b stall=%b, want 10 10 0", adepend, bdepend, stall);
      end
      tick();
   endtask

   task automatic test_load_use();
      int stalls = 0;
      do_reset();
      drive(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0); // lw r7
      tick();
      drive(5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0); // sw r7
      checks++;
      if (stall !== 1'b1 || bubble !== 1'b1) begin
         errors++;
         $display("FAIL load_use_stall: got stall=%b bubble=%b, want 1 1", stall, bubble);
      end
      if (stall) stalls++;
      tick();
      drive(5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0); // same sw
      checks++;
      if (sdepend !== 2'b11 || stall !== 1'b0 || bubble !== 1'b0 || bdepend !== 2'b00) begin
         errors++;
         $display("FAIL load_use_fwd: got s=%b b=%b stall=%b bubble=%b, want 11 00 0 0",
                  sdepend, bdepend, stall, bubble);
      end
      if (stall) stalls++;
      tick();
      nop();
      if (stall) stalls++;
      checks++;
      if (stalls != 1) begin
         errors++;
         $display("FAIL load_use_count: got %0d stall cycles, want 1", stalls);
      end
      tick();
   endtask

   task automatic test_priority();
      do_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0);
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0);
      tick();
      drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (adepend !== 2'b01) begin
         errors++;
         $display("FAIL e_priority: got a=%b, want 01", adepend);
      end
      tick();
      // r0 writers never forward
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (adepend !== 2'b00 || bdepend !== 2'b00 || stall !== 1'b0) begin
         errors++;
         $display("FAIL r0_no_fwd: got a=%b b=%b stall=%b, want 00 00 0", adepend, bdepend, stall);
      end
      tick();
      // load already in M forwards memory data without stalling
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0);
      tick();
      nop();
      tick();
      drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (adepend !== 2'b11 || stall !== 1'b0) begin
         errors++;
         $display("FAIL m_load_fwd: got a=%b stall=%b, want 11 0", adepend, stall);
      end
      tick();
   endtask

   task automatic test_flush();
      do_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1); // killed write r4
      checks++;
      if (bubble !== 1'b1 || stall !== 1'b0) begin
         errors++;
         $display("FAIL flush_bubble: got bubble=%b stall=%b, want 1 0", bubble, stall);
      end
      tick();
      drive(5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (adepend !== 2'b00 || bdepend !== 2'b00 || bubble !== 1'b0) begin
         errors++;
         $display("FAIL flush_phantom: got a=%b b=%b bubble=%b, want 00 00 0",
                  adepend, bdepend, bubble);
      end
      tick();
      // flush coinciding with a load-use stall
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0);
      tick();
      drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      checks++;
      if (stall !== 1'b1 || bubble !== 1'b1) begin
         errors++;
         $display("FAIL flush_and_stall: got stall=%b bubble=%b, want 1 1", stall, bubble);
      end
      tick();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0);
      tick();
      drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick(); // one stall cycle counted
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0);
      tick();
      drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_stall: got stall=%b, want 1", stall);
      end
      clrn = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || bubble !== 1'b0 || adepend !== 2'b00) begin
         errors++;
         $display("FAIL async_reset_stall: got stall=%b bubble=%b a=%b, want 0 0 00",
                  stall, bubble, adepend);
      end
`ifdef HAZ_PERF_CNT_EN
      checks++;
      if (stall_cnt !== 32'd0 || fwd_cnt !== 32'd0) begin
         errors++;
         $display("FAIL async_reset_cnt: got stall_cnt=%0d fwd_cnt=%0d, want 0 0",
                  stall_cnt, fwd_cnt);
      end
`endif
      @(negedge clk);
      clrn = 1'b1;
      tick();
   endtask

`ifdef HAZ_PERF_CNT_EN
   task automatic test_perf_cnt();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0); // lw r7
         tick();
         drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); // stalls
         tick();
         drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); // forwards 11
         tick();
         nop();
         tick();
      end
      checks++;
      if (stall_cnt !== 32'd3 || fwd_cnt !== 32'd3) begin
         errors++;
         $display("FAIL perf_cnt: got stall_cnt=%0d fwd_cnt=%0d, want 3 3", stall_cnt, fwd_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_empty();
      test_forward_e();
      test_forward_m();
      test_load_use();
      test_priority();
      test_flush();
`ifdef HAZ_PERF_CNT_EN
      test_perf_cnt();
`endif
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
